// File: rtl/pwm_ramp_pkg.sv
// Shared types and widths for the PWM duty ramp generator.
// step_toward() moves a duty value one step toward its target without overshoot or wrap.
package pwm_ramp_pkg;

  localparam int DUTY_W     = 8;
  localparam int TICK_W     = 8;
  localparam int PRESCALE_W = 8;
  localparam int RAMP_W     = 8;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    RAMP = 2'd2,
    LOAD = 2'd3
  } state_e;

  // Arithmetic is done 9 bits wide so that cur+step and tgt+step cannot wrap.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W:0]   step);
    logic [DUTY_W:0] cur9;
    logic [DUTY_W:0] tgt9;
    logic [DUTY_W:0] res9;
    cur9 = {1'b0, cur};
    tgt9 = {1'b0, tgt};
    if (cur9 < tgt9) begin
      res9 = (cur9 + step >= tgt9) ? tgt9 : cur9 + step;
    end else begin
      res9 = (cur9 < tgt9 + step) ? tgt9 : cur9 - step;
    end
    return DUTY_W'(res9);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk by PRESCALE into a registered one-clk count-enable strobe.
// The first strobe appears PRESCALE clks after reset release.
module pwm_prescaler
  import pwm_ramp_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  output logic ce_out
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;
  logic                  ce_q;
  logic                  ce_d;

  always_comb begin
    ce_d  = (cnt_q == LAST);
    cnt_d = ce_d ? '0 : cnt_q + PRESCALE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_out = ce_q;

endmodule

// File: rtl/pwm_ramp.sv
// Slews the PWM duty toward a host target one STEP per RAMP_CYCLES PWM periods,
// issuing a load strobe for each new duty; stop forces duty to 0 immediately.
module pwm_ramp
  import pwm_ramp_pkg::*;
#(
  parameter int PRESCALE    = 4,
  parameter int RAMP_CYCLES = 1,
  parameter int STEP        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tgtld,
  input  logic [DUTY_W-1:0] tgtdata,
  input  logic              stop,
  output logic              pwmcntce,
  output logic              pwmldce,
  output logic [DUTY_W-1:0] wrtdata,
  output logic [DUTY_W-1:0] duty,
  output logic              busy
);

  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
  localparam logic [DUTY_W:0]   STEP_9    = (DUTY_W + 1)'(STEP);

  logic ce;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .ce_out (ce)
  );

  state_e              state_q,  state_d;
  logic [TICK_W-1:0]   tick_q,   tick_d;
  logic [RAMP_W-1:0]   ramp_q,   ramp_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic [DUTY_W-1:0]   duty_q,   duty_d;
  logic [DUTY_W-1:0]   wrt_q,    wrt_d;
  logic                ld_q,     ld_d;
  logic                stop_q,   stop_d;
  logic                step_evt;

  // Free-running period/step timing; not aligned to the channel's own counter.
  always_comb begin
    tick_d   = tick_q;
    ramp_d   = ramp_q;
    step_evt = 1'b0;
    if (ce) begin
      tick_d = tick_q + TICK_W'(1);
      if (tick_q == '1) begin
        if (ramp_q == RAMP_LAST) begin
          ramp_d   = '0;
          step_evt = 1'b1;
        end else begin
          ramp_d = ramp_q + RAMP_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = tgtld ? tgtdata : target_q;
    duty_d   = duty_q;
    stop_d   = stop;
    ld_d     = (state_q == SYNC) || (state_q == LOAD);
    wrt_d    = wrt_q;
    if (state_q == LOAD) wrt_d = duty_q;
    if (state_q == SYNC) wrt_d = '0;

    case (state_q)
      SYNC: state_d = IDLE;
      IDLE: if (duty_q != target_q) state_d = RAMP;
      RAMP: begin
        if (step_evt) begin
          if (duty_q == target_q) begin
            state_d = IDLE;
          end else begin
            duty_d  = step_toward(duty_q, target_q, STEP_9);
            state_d = LOAD;
          end
        end
      end
      LOAD:    state_d = (duty_q != target_q) ? RAMP : IDLE;
      default: state_d = SYNC;
    endcase

    // Only the rising edge of stop schedules a load, so a held stop pulses once.
    if (stop) begin
      target_d = '0;
      duty_d   = '0;
      if (!stop_q) state_d = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SYNC;
      tick_q   <= '0;
      ramp_q   <= '0;
      target_q <= '0;
      duty_q   <= '0;
      wrt_q    <= '0;
      ld_q     <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      ramp_q   <= ramp_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      wrt_q    <= wrt_d;
      ld_q     <= ld_d;
      stop_q   <= stop_d;
    end
  end

  assign pwmcntce = ce;
  assign pwmldce  = ld_q;
  assign wrtdata  = wrt_q;
  assign duty     = duty_q;
  assign busy     = (duty_q != target_q);

endmodule
